// File: rtl/xoodoo_sca_seq_pkg.sv
// ============================================================================
// xoodoo_sca_seq_pkg -- widths, round constants and FSM states for the
// masked Xoodoo round sequencer.                               Rev 1.0
// ============================================================================
`default_nettype none

package xoodoo_sca_seq_pkg;

  localparam int STATE_W = 384;
  localparam int LANE_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD0 = 3'd1,
    ST_LOAD1 = 3'd2,
    ST_EVAL  = 3'd3,
    ST_CAPT  = 3'd4
  } state_e;

  // Indices past the end of the table yield zero.
  function automatic logic [LANE_W-1:0] rc_lookup(input logic [3:0] idx);
    case (idx)
      4'd0:    rc_lookup = 32'h0000_0058;
      4'd1:    rc_lookup = 32'h0000_0038;
      4'd2:    rc_lookup = 32'h0000_03C0;
      4'd3:    rc_lookup = 32'h0000_00D0;
      4'd4:    rc_lookup = 32'h0000_0120;
      4'd5:    rc_lookup = 32'h0000_0014;
      4'd6:    rc_lookup = 32'h0000_0060;
      4'd7:    rc_lookup = 32'h0000_002C;
      4'd8:    rc_lookup = 32'h0000_0380;
      4'd9:    rc_lookup = 32'h0000_00F0;
      4'd10:   rc_lookup = 32'h0000_01A0;
      4'd11:   rc_lookup = 32'h0000_0012;
      default: rc_lookup = 32'h0000_0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/xoodoo_sca_seq.sv
// ============================================================================
// xoodoo_sca_seq -- sequencer driving an external masked Xoodoo round core
// through NROUNDS rounds with streamed fresh randomness.       Rev 1.0
// ============================================================================
`default_nettype none

module xoodoo_sca_seq
  import xoodoo_sca_seq_pkg::*;
#(
  parameter int NROUNDS = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in_0,
  input  logic [STATE_W-1:0] state_in_1,
  output logic               ready,
  output logic               done,
  output logic [STATE_W-1:0] state_out_0,
  output logic [STATE_W-1:0] state_out_1,
  input  logic [STATE_W-1:0] rnd_i,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  output logic [STATE_W-1:0] core_in_0,
  output logic [STATE_W-1:0] core_in_1,
  output logic [STATE_W-1:0] core_rdi,
  output logic               core_rdi0_en,
  output logic               core_rdi1_en,
  output logic [LANE_W-1:0]  core_rconst,
  input  logic [STATE_W-1:0] core_out_0,
  input  logic [STATE_W-1:0] core_out_1
);

  // Shorter permutations use the tail of the constant table.
  localparam logic [3:0] RC_BASE    = 4'(12 - NROUNDS);
  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

  state_e             state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic [STATE_W-1:0] share0_q, share0_d;
  logic [STATE_W-1:0] share1_q, share1_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      round_q  <= 4'd0;
      share0_q <= '0;
      share1_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      share0_q <= share0_d;
      share1_q <= share1_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    share0_d     = share0_q;
    share1_d     = share1_q;
    done_d       = 1'b0;
    ready        = 1'b0;
    rnd_ready    = 1'b0;
    core_rdi0_en = 1'b0;
    core_rdi1_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          share0_d = state_in_0;
          share1_d = state_in_1;
          round_d  = 4'd0;
          state_d  = ST_LOAD0;
        end
      end
      ST_LOAD0: begin
        rnd_ready    = 1'b1;
        core_rdi0_en = rnd_valid;
        if (rnd_valid) state_d = ST_LOAD1;
      end
      ST_LOAD1: begin
        rnd_ready    = 1'b1;
        core_rdi1_en = rnd_valid;
        if (rnd_valid) state_d = ST_EVAL;
      end
      ST_EVAL: state_d = ST_CAPT;
      ST_CAPT: begin
        share0_d = core_out_0;
        share1_d = core_out_1;
        round_d  = round_q + 4'd1;
        if (round_q == LAST_ROUND) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_LOAD0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done        = done_q;
  assign state_out_0 = share0_q;
  assign state_out_1 = share1_q;
  assign core_in_0   = share0_q;
  assign core_in_1   = share1_q;
  assign core_rdi    = rnd_i;
  assign core_rconst = rc_lookup(RC_BASE + round_q);

endmodule

`default_nettype wire
